rs_issue_queue: RTL
===================

// Module: rs_issue_queue
// PURPOSE
//  Parametrised reservation station for ALU/branch ops, between dispatcher and EX unit.
//  Holds RS_DEPTH ops waiting on ROB-tagged operands and snoops CDB_NUM broadcast buses for wakeup.
//  Issues one ready op per cycle to EX over a valid/ready handshake.
//  Tracks a live free-entry count, and flushes completely on ROB rollback.
// PARAMETERS
//  RS_DEPTH   16  entries; power of two, 2..64
//  CDB_NUM    2   number of CDB wakeup channels (ALU cdb, LS cdb, ...)
//  DATA_W     32  operand / pc / imm width
//  ROB_ID_W   4   ROB tag width; tag 0 reserved = "no dependency"
//  OPENUM_W   6   opcode enum width
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  async reset, active-high
//  rdy          in   1                  global ready; 0 freezes all state
//  rollback_i   in   1                  ROB mispredict flush
//  in_valid     in   1                  dispatch op present
//  in_openum    in   OPENUM_W           op enum
//  in_v1/in_v2  in   DATA_W             operand values (valid when matching q is 0)
//  in_q1/in_q2  in   ROB_ID_W           operand producer tags
//  in_pc/in_imm in   DATA_W             pc, immediate
//  in_rob_id    in   ROB_ID_W           destination ROB tag
//  full_o       out  1                  no free entry
//  free_cnt_o   out  $clog2(RS_DEPTH)+1 free entries
//  cdb_valid    in   CDB_NUM            per-channel broadcast valid
//  cdb_rob_id   in   CDB_NUM*ROB_ID_W   packed tags, channel 0 in LSBs
//  cdb_result   in   CDB_NUM*DATA_W     packed results
//  ex_valid     out  1                  issue slot valid
//  ex_ready     in   1                  EX accepts
//  ex_openum/ex_v1/ex_v2/ex_pc/ex_imm/ex_rob_id  out  as above  issued op
// BEHAVIOUR
//  - Reset (async): all busy=0, ex_valid=0, ex_* data=0, ex_openum=OPENUM_NOP, free_cnt_o=RS_DEPTH, full_o=0.
//  - Priority per posedge: rollback_i > ~rdy (hold all) > normal. rollback clears busy, ex_valid next edge.
//  - Insert: if in_valid && !full_o, write lowest-index free entry. in_valid while full_o is dropped silently.
//  - Insert bypass: in_qX equal to a valid cdb tag -> store qX=0, vX=that result. Lowest channel wins on duplicates.
//  - Wakeup: each busy entry with qX!=0 matching a valid cdb channel -> qX<=0, vX<=result.
//    Operands woken this cycle become eligible for selection next cycle.
//  - Ready entry: busy && q1==0 && q2==0 (registered values only).
//  - Issue reg loads when (!ex_valid || ex_ready) and a ready entry exists.
//    On load, entry busy<=0 and ex_valid<=1. Nothing ready -> ex_valid<=0 when slot drained.
//  - Stall: ex_valid && !ex_ready -> ex_* held stable, no entry consumed.
//  - Latency: op with ready operands inserted at edge N appears on ex_* after edge N+1.
//  - free_cnt_o/full_o: combinational from registered busy. Same-cycle free+insert is net-zero.
//    A slot freed this cycle is not reusable until next cycle.
//  - Tag 0 never matched against the CDB.
// CONFIGURATION
//  RS_AGE_ORDER_EN defined: RS_DEPTH x RS_DEPTH age matrix.
//    Select oldest ready entry (by insert order); matrix row/col updated on insert.
//  Undefined: select lowest-index ready entry; no age storage. Functionally correct, not age-fair.
// STRUCTURE
//  rs_pkg: ZERO_ROB, OPENUM_NOP, width localparams, packed rs_entry_t {busy,openum,v1,v2,q1,q2,pc,imm,rob_id}.
//  Sub-module rs_prio_pick: N-bit request (+optional age matrix) -> one-hot grant + index + any.
//    Instantiated twice: free-slot pick and issue pick.
// TESTING
//  1 Reset mid-stream with 3 entries busy -> ex_valid=0 immediately, free_cnt_o=16.
//  2 Insert q1=q2=0, rob 5, ex_ready=1 -> ex_valid=1, ex_rob_id=5 one cycle later. Entry freed.
//  3 Insert q1=3 while cdb0 {1,3,0xAB} same cycle -> v1=0xAB, issues next cycle.
//  4 Insert q1=4 and q2=7; cdb0=4, cdb1=7 same later cycle -> both woken, issue following cycle.
//  5 Fill 16, ex_ready=0 -> full_o=1, 17th insert dropped, ex_* held stable.
//    Then ex_ready=1 -> one issue per cycle.
//  6 With RS_AGE_ORDER_EN: insert A(idx3), B(idx0) both ready -> A issues first. Without: B first.
//    rollback_i with ex_valid=1 -> all cleared next edge.

Source files
------------

// File: rtl/rs_issue_queue_pkg.sv
// Shared types and constants for the reservation-station issue queue.
package rs_issue_queue_pkg;

  localparam int RS_DATA_W   = 32;
  localparam int RS_ROB_ID_W = 4;
  localparam int RS_OPENUM_W = 6;

  // ROB tag 0 means the operand value is already present.
  localparam logic [RS_ROB_ID_W-1:0] ZERO_ROB   = '0;
  localparam logic [RS_OPENUM_W-1:0] OPENUM_NOP = '0;

  typedef struct packed {
    logic                   busy;
    logic [RS_OPENUM_W-1:0] openum;
    logic [RS_DATA_W-1:0]   v1;
    logic [RS_DATA_W-1:0]   v2;
    logic [RS_ROB_ID_W-1:0] q1;
    logic [RS_ROB_ID_W-1:0] q2;
    logic [RS_DATA_W-1:0]   pc;
    logic [RS_DATA_W-1:0]   imm;
    logic [RS_ROB_ID_W-1:0] rob_id;
  } rs_entry_t;

endpackage

// File: rtl/rs_issue_queue_if.sv
// Dispatch, CDB snoop and EX issue signals of the reservation station.
interface rs_issue_queue_if
  import rs_issue_queue_pkg::*;
#(
  parameter int CDB_NUM  = 2,
  parameter int DATA_W   = RS_DATA_W,
  parameter int ROB_ID_W = RS_ROB_ID_W,
  parameter int OPENUM_W = RS_OPENUM_W
);
  logic                         in_valid;
  logic [OPENUM_W-1:0]          in_openum;
  logic [DATA_W-1:0]            in_v1;
  logic [DATA_W-1:0]            in_v2;
  logic [ROB_ID_W-1:0]          in_q1;
  logic [ROB_ID_W-1:0]          in_q2;
  logic [DATA_W-1:0]            in_pc;
  logic [DATA_W-1:0]            in_imm;
  logic [ROB_ID_W-1:0]          in_rob_id;

  logic [CDB_NUM-1:0]           cdb_valid;
  logic [CDB_NUM*ROB_ID_W-1:0]  cdb_rob_id;
  logic [CDB_NUM*DATA_W-1:0]    cdb_result;

  logic                         ex_valid;
  logic                         ex_ready;
  logic [OPENUM_W-1:0]          ex_openum;
  logic [DATA_W-1:0]            ex_v1;
  logic [DATA_W-1:0]            ex_v2;
  logic [DATA_W-1:0]            ex_pc;
  logic [DATA_W-1:0]            ex_imm;
  logic [ROB_ID_W-1:0]          ex_rob_id;

  modport master (
    output in_valid, in_openum, in_v1, in_v2, in_q1, in_q2, in_pc, in_imm, in_rob_id,
    output cdb_valid, cdb_rob_id, cdb_result, ex_ready,
    input  ex_valid, ex_openum, ex_v1, ex_v2, ex_pc, ex_imm, ex_rob_id
  );

  modport slave (
    input  in_valid, in_openum, in_v1, in_v2, in_q1, in_q2, in_pc, in_imm, in_rob_id,
    input  cdb_valid, cdb_rob_id, cdb_result, ex_ready,
    output ex_valid, ex_openum, ex_v1, ex_v2, ex_pc, ex_imm, ex_rob_id
  );
endinterface

// File: rtl/rs_issue_queue_prio_pick.sv
// Priority picker: older[j][i]=1 means requester j beats requester i.
// Produces a one-hot grant, its binary index and an any-request flag.
module rs_prio_pick #(
  parameter int N = 16
) (
  input  logic [N-1:0]          req,
  input  logic [N-1:0][N-1:0]   older,
  output logic [N-1:0]          gnt,
  output logic [$clog2(N)-1:0]  idx,
  output logic                  any
);
  localparam int IW = $clog2(N);

  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = req[i];
      for (int j = 0; j < N; j++) begin
        if (req[j] && older[j][i]) gnt[i] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) idx = idx | IW'(i);
    end
    any = |req;
  end
endmodule

// File: rtl/rs_issue_queue.sv
// Reservation station: holds ops until CDB wakeup, issues one ready op per cycle.
// Optional macro RS_AGE_ORDER_EN selects oldest-ready issue via an age matrix.
module rs_issue_queue
  import rs_issue_queue_pkg::*;
#(
  parameter int RS_DEPTH = 16,
  parameter int CDB_NUM  = 2,
  parameter int DATA_W   = RS_DATA_W,
  parameter int ROB_ID_W = RS_ROB_ID_W,
  parameter int OPENUM_W = RS_OPENUM_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      rollback_i,
  rs_issue_queue_if.slave           io,
  output logic                      full_o,
  output logic [$clog2(RS_DEPTH):0] free_cnt_o
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t ent_q [RS_DEPTH];
  rs_entry_t ent_d [RS_DEPTH];
  rs_entry_t new_ent;

  logic                ex_valid_q, ex_valid_d;
  logic [OPENUM_W-1:0] ex_openum_q, ex_openum_d;
  logic [DATA_W-1:0]   ex_v1_q, ex_v1_d, ex_v2_q, ex_v2_d;
  logic [DATA_W-1:0]   ex_pc_q, ex_pc_d, ex_imm_q, ex_imm_d;
  logic [ROB_ID_W-1:0] ex_rob_id_q, ex_rob_id_d;

  logic [RS_DEPTH-1:0]               busy_vec, free_vec, ready_vec;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] idx_pri, issue_pri;
  logic [RS_DEPTH-1:0]               ins_gnt, iss_gnt;
  logic [IDX_W-1:0]                  ins_idx, iss_idx;
  logic                              ins_any, iss_any;
  logic [CNT_W-1:0]                  free_cnt;
  logic                              slot_open, do_issue, do_insert;
  logic [DATA_W:0]                   ins_hit1, ins_hit2;

  logic [CDB_NUM-1:0]          cdb_valid;
  logic [CDB_NUM*ROB_ID_W-1:0] cdb_rob_id;
  logic [CDB_NUM*DATA_W-1:0]   cdb_result;

  assign cdb_valid  = io.cdb_valid;
  assign cdb_rob_id = io.cdb_rob_id;
  assign cdb_result = io.cdb_result;

  // Returns {hit, value}; scanning from the top lets channel 0 win duplicates.
  function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_ID_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int c = CDB_NUM - 1; c >= 0; c--) begin
      if (cdb_valid[c] && tag != ZERO_ROB && cdb_rob_id[c*ROB_ID_W +: ROB_ID_W] == tag)
        r = {1'b1, cdb_result[c*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      busy_vec[i]  = ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && ent_q[i].q1 == ZERO_ROB && ent_q[i].q2 == ZERO_ROB;
      for (int j = 0; j < RS_DEPTH; j++) idx_pri[j][i] = (j < i);
    end
  end

  assign free_vec = ~busy_vec;

  rs_prio_pick #(.N(RS_DEPTH)) u_free_pick (
    .req(free_vec), .older(idx_pri), .gnt(ins_gnt), .idx(ins_idx), .any(ins_any)
  );

  rs_prio_pick #(.N(RS_DEPTH)) u_issue_pick (
    .req(ready_vec), .older(issue_pri), .gnt(iss_gnt), .idx(iss_idx), .any(iss_any)
  );

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < RS_DEPTH; i++) free_cnt = free_cnt + CNT_W'(free_vec[i]);
  end

  assign free_cnt_o = free_cnt;
  assign full_o     = ~ins_any;
  assign slot_open  = !ex_valid_q || io.ex_ready;
  assign do_issue   = slot_open && iss_any;
  assign do_insert  = io.in_valid && ins_any;

  always_comb begin
    ins_hit1       = cdb_lookup(io.in_q1);
    ins_hit2       = cdb_lookup(io.in_q2);
    new_ent.busy   = 1'b1;
    new_ent.openum = io.in_openum;
    new_ent.v1     = ins_hit1[DATA_W] ? ins_hit1[DATA_W-1:0] : io.in_v1;
    new_ent.q1     = ins_hit1[DATA_W] ? ZERO_ROB : io.in_q1;
    new_ent.v2     = ins_hit2[DATA_W] ? ins_hit2[DATA_W-1:0] : io.in_v2;
    new_ent.q2     = ins_hit2[DATA_W] ? ZERO_ROB : io.in_q2;
    new_ent.pc     = io.in_pc;
    new_ent.imm    = io.in_imm;
    new_ent.rob_id = io.in_rob_id;
  end

  // Next state: rollback beats the rdy freeze, which beats normal operation.
  always_comb begin
    logic [DATA_W:0] wk1, wk2;
    wk1         = '0;
    wk2         = '0;
    ent_d       = ent_q;
    ex_valid_d  = ex_valid_q;
    ex_openum_d = ex_openum_q;
    ex_v1_d     = ex_v1_q;
    ex_v2_d     = ex_v2_q;
    ex_pc_d     = ex_pc_q;
    ex_imm_d    = ex_imm_q;
    ex_rob_id_d = ex_rob_id_q;
    if (rollback_i) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_d[i].busy = 1'b0;
      ex_valid_d = 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (ent_q[i].busy) begin
          wk1 = cdb_lookup(ent_q[i].q1);
          wk2 = cdb_lookup(ent_q[i].q2);
          if (wk1[DATA_W]) begin
            ent_d[i].q1 = ZERO_ROB;
            ent_d[i].v1 = wk1[DATA_W-1:0];
          end
          if (wk2[DATA_W]) begin
            ent_d[i].q2 = ZERO_ROB;
            ent_d[i].v2 = wk2[DATA_W-1:0];
          end
        end
      end
      if (do_issue) begin
        ent_d[iss_idx].busy = 1'b0;
        ex_valid_d  = 1'b1;
        ex_openum_d = ent_q[iss_idx].openum;
        ex_v1_d     = ent_q[iss_idx].v1;
        ex_v2_d     = ent_q[iss_idx].v2;
        ex_pc_d     = ent_q[iss_idx].pc;
        ex_imm_d    = ent_q[iss_idx].imm;
        ex_rob_id_d = ent_q[iss_idx].rob_id;
      end else if (slot_open) begin
        ex_valid_d = 1'b0;
      end
      // The free pick only sees non-busy slots, so it never collides with the issue slot.
      if (do_insert) ent_d[ins_idx] = new_ent;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
      ex_valid_q  <= 1'b0;
      ex_openum_q <= OPENUM_NOP;
      ex_v1_q     <= '0;
      ex_v2_q     <= '0;
      ex_pc_q     <= '0;
      ex_imm_q    <= '0;
      ex_rob_id_q <= '0;
    end else begin
      ent_q       <= ent_d;
      ex_valid_q  <= ex_valid_d;
      ex_openum_q <= ex_openum_d;
      ex_v1_q     <= ex_v1_d;
      ex_v2_q     <= ex_v2_d;
      ex_pc_q     <= ex_pc_d;
      ex_imm_q    <= ex_imm_d;
      ex_rob_id_q <= ex_rob_id_d;
    end
  end

`ifdef RS_AGE_ORDER_EN
  // age_q[j][i]=1: entry j was inserted before entry i, so j wins the issue pick.
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (!rollback_i && rdy && do_insert) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        age_d[ins_idx][j] = 1'b0;
        age_d[j][ins_idx] = (j != int'(ins_idx));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end

  assign issue_pri = age_q;
`else
  assign issue_pri = idx_pri;
`endif

  assign io.ex_valid  = ex_valid_q;
  assign io.ex_openum = ex_openum_q;
  assign io.ex_v1     = ex_v1_q;
  assign io.ex_v2     = ex_v2_q;
  assign io.ex_pc     = ex_pc_q;
  assign io.ex_imm    = ex_imm_q;
  assign io.ex_rob_id = ex_rob_id_q;
endmodule
